// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and a saturating back-pressure cycle counter.
module pipe_stage_hs #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID      = 1'b1,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a transfer happens on the rising edge ending a cycle in which
  // valid and ready are both high on that side of the stage.
  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  if (SKID) begin : g_skid
    state_t            state_q, state_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic              in_ready_q;

    always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = BUSY;
            m_d     = in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            m_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            s_d     = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = BUSY;
            m_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
      // Flush wins over any capture; the output side may still complete.
      if (flush) begin
        state_d = EMPTY;
        m_d     = RESET_VAL;
        s_d     = RESET_VAL;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q    <= EMPTY;
        m_q        <= RESET_VAL;
        s_q        <= RESET_VAL;
        in_ready_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        m_q        <= m_d;
        s_q        <= s_d;
        in_ready_q <= (state_d != FULL);
      end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = m_q;
    assign occupancy = state_q;
  end else begin : g_pass
    logic              valid_q;
    logic [DATA_W-1:0] m_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        m_q     <= RESET_VAL;
      end else if (flush) begin
        valid_q <= 1'b0;
        m_q     <= RESET_VAL;
      end else if (in_fire) begin
        valid_q <= 1'b1;
        m_q     <= in_data;
      end else if (out_fire) begin
        valid_q <= 1'b0;
      end
    end

    // Combinational ready lets a draining register refill in the same cycle.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = m_q;
    assign occupancy = {1'b0, valid_q};
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: a skid instance (CNT_W=4) and a pass-through
// instance share stimulus; each is compared every cycle with a FIFO model.
module tb_pipe_stage_hs;

  typedef logic [31:0] word_q_t[$];

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_occ;
  logic [3:0]  s_stall;

  logic        p_in_ready, p_out_valid;
  logic [31:0] p_out_data;
  logic [1:0]  p_occ;
  logic [15:0] p_stall;

  int total = 0;
  int bad   = 0;

  // Model state per instance: held entries (oldest first), last shown data, stall count.
  word_q_t     exp_q;
  logic [31:0] s_hold = '0;
  int          s_cnt  = 0;
  word_q_t     p_q;
  logic [31:0] p_hold = '0;
  int          p_cnt  = 0;

  pipe_stage_hs #(.DATA_W(32), .SKID(1'b1), .CNT_W(4)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occ), .stall_cnt(s_stall)
  );

  pipe_stage_hs #(.DATA_W(32), .SKID(1'b0), .CNT_W(16)) u_pass (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(p_in_ready), .in_data(in_data),
    .out_valid(p_out_valid), .out_ready(out_ready), .out_data(p_out_data),
    .occupancy(p_occ), .stall_cnt(p_stall)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready(input bit skid, input int size, input logic ordy);
    if (skid) return size < 2;
    return (size == 0) || ordy;
  endfunction

  task automatic model_step(input bit skid, input int max_cnt, inout word_q_t q,
                            inout logic [31:0] hold, inout int cnt);
    bit in_f, out_f;
    in_f  = in_valid && exp_ready(skid, q.size(), out_ready);
    out_f = (q.size() > 0) && out_ready;
    if (q.size() > 0 && !out_ready && cnt < max_cnt) cnt++;
    if (flush) begin
      q.delete();
      hold = '0;
    end else begin
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(in_data);
    end
    if (q.size() > 0) hold = q[0];
  endtask

  // Inputs only change just after posedge, so the falling edge sees the
  // values that the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); s_hold = '0; s_cnt = 0;
      p_q.delete();   p_hold = '0; p_cnt = 0;
    end else begin
      chk("skid_in_ready",  s_in_ready,  exp_ready(1'b1, exp_q.size(), out_ready));
      chk("skid_out_valid", s_out_valid, exp_q.size() > 0);
      chk("skid_out_data",  s_out_data,  s_hold);
      chk("skid_occupancy", s_occ,       exp_q.size());
      chk("skid_stall_cnt", s_stall,     s_cnt);
      chk("pass_in_ready",  p_in_ready,  exp_ready(1'b0, p_q.size(), out_ready));
      chk("pass_out_valid", p_out_valid, p_q.size() > 0);
      chk("pass_out_data",  p_out_data,  p_hold);
      chk("pass_occupancy", p_occ,       p_q.size());
      chk("pass_stall_cnt", p_stall,     p_cnt);
      model_step(1'b1, 15,    exp_q, s_hold, s_cnt);
      model_step(1'b0, 65535, p_q,   p_hold, p_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (n) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("rst_in_ready", s_in_ready, 1'b1);
    chk("rst_out_valid", s_out_valid, 1'b0);
    chk("rst_occ", s_occ, 2'd0);
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_rel_in_ready", s_in_ready, 1'b1);
    chk("rst_rel_out_data", s_out_data, 32'h0);

    // Full throughput: one value per cycle, no back-pressure.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i, 1'b1, 1'b0);
      tick();
      chk("thru_data", s_out_data, i);
      chk("thru_occ", s_occ, 2'd1);
      chk("thru_in_ready", s_in_ready, 1'b1);
    end
    idle_cycles(2);

    // Back-pressure into the skid register.
    drive(1'b1, 32'hA, 1'b0, 1'b0); tick();
    chk("bp_occ1", s_occ, 2'd1);
    chk("bp_rdy1", s_in_ready, 1'b1);
    drive(1'b1, 32'hB, 1'b0, 1'b0); tick();
    chk("bp_occ2", s_occ, 2'd2);
    chk("bp_rdy2", s_in_ready, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0); tick();
    chk("bp_hold_data", s_out_data, 32'hA);
    tick();
    chk("bp_stall", s_stall, 4'd3);
    drive(1'b1, 32'hC, 1'b1, 1'b0); tick();
    chk("bp_out_b", s_out_data, 32'hB);
    tick();
    chk("bp_out_c", s_out_data, 32'hC);
    chk("bp_occ_c", s_occ, 2'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    chk("bp_drained_valid", s_out_valid, 1'b0);
    chk("bp_drained_data", s_out_data, 32'hC);
    chk("bp_stall_final", s_stall, 4'd3);

    // Flush colliding with in_fire and out_fire.
    drive(1'b1, 32'h5, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h6, 1'b0, 1'b0); tick();
    chk("fl_full", s_occ, 2'd2);
    drive(1'b1, 32'h7, 1'b1, 1'b1);
    chk("fl_head", s_out_data, 32'h5);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("fl_occ", s_occ, 2'd0);
    chk("fl_valid", s_out_valid, 1'b0);
    chk("fl_data", s_out_data, 32'h0);
    chk("fl_rdy", s_in_ready, 1'b1);
    idle_cycles(2);

    // Asynchronous reset between edges while FULL.
    drive(1'b1, 32'h11, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h22, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("mr_full", s_occ, 2'd2);
    #2 rst = 1'b1;
    #1;
    chk("mr_valid", s_out_valid, 1'b0);
    chk("mr_occ", s_occ, 2'd0);
    chk("mr_data", s_out_data, 32'h0);
    chk("mr_stall", s_stall, 4'd0);
    chk("mr_rdy", s_in_ready, 1'b1);
    tick();
    rst = 1'b0;
    idle_cycles(1);

    // Pass-through: combinational in_ready, no bubble on back-to-back.
    drive(1'b1, 32'h1, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h2, 1'b0, 1'b0);
    #1;
    chk("pt_rdy_low", p_in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("pt_rdy_comb", p_in_ready, 1'b1);
    tick();
    chk("pt_valid2", p_out_valid, 1'b1);
    chk("pt_data2", p_out_data, 32'h2);
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    chk("pt_empty", p_out_valid, 1'b0);
    idle_cycles(2);

    // Stall counter saturation and flush immunity.
    drive(1'b1, 32'h33, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (20) tick();
    chk("sat_cnt", s_stall, 4'd15);
    drive(1'b0, 32'h0, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sat_after_flush", s_stall, 4'd15);
    chk("sat_flush_occ", s_occ, 2'd0);
    idle_cycles(2);

    // Randomized traffic; data held stable while offered.
    for (int i = 0; i < 3000; i++) begin
      logic v;
      logic [31:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = (in_valid && !s_in_ready) ? in_data : $urandom();
      drive(v, d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
      tick();
    end
    idle_cycles(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
